rf_write_arbiter: RTL and testbench
===================================

Name: rf_write_arbiter

Overview:
Shares the register file's single write port between two writeback sources. Source A is the in-order pipeline writeback stage. Source B is the multi-cycle unit writeback (mul/div, load-miss return). The arbiter uses fixed priority to A, with an anti-starvation override for B, and presents a registered write command to the register file. Writes to r0 are consumed and never forwarded.

Parameters:
DATA_W, 32, width of the write data.
ADDR_W, 5, width of the register address.
MAX_WAIT, 4, number of consecutive cycles B may be valid and lose before it is force-granted (range 1..15).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
a_valid  in  1  source A has a write pending.
a_addr  in  ADDR_W  source A destination register.
a_data  in  DATA_W  source A write data.
a_ready  out  1  source A accepted this cycle (combinational).
b_valid  in  1  source B has a write pending.
b_addr  in  ADDR_W  source B destination register.
b_data  in  DATA_W  source B write data.
b_ready  out  1  source B accepted this cycle (combinational).
rf_we  out  1  write enable to the register file (registered).
rf_addr  out  ADDR_W  write address to the register file (registered).
rf_data  out  DATA_W  write data to the register file (registered).
b_starved  out  1  high in any cycle where B is force-granted (combinational; debug/perf).
wait_cnt  out  4  current starvation counter value (registered).

Behaviour:
- Handshake: a transfer occurs when valid && ready. A source holds valid/addr/data stable until accepted. At most one source is accepted per cycle.
- Ready logic is combinational from the valids and wait_cnt; there is no backpressure from the register file.
- Arbitration FSM, with state = wait_cnt:
  - Normal, wait_cnt < MAX_WAIT:
    - a_valid → grant A.
    - else b_valid → grant B.
  - Force, wait_cnt == MAX_WAIT and b_valid → grant B. a_ready = 0 and b_starved = 1.
  - Force with !b_valid cannot occur, because the counter clears (see the counter rule).
- Counter rule:
  - Cycle with b_valid && !b_ready → wait_cnt <= wait_cnt + 1, saturating at MAX_WAIT.
  - Otherwise → wait_cnt <= 0. This includes B granted and B not valid.
- Write command, registered with 1-cycle latency from the accept:
  - Accepted source with addr != 0 → next cycle rf_we = 1 and rf_addr/rf_data = the accepted addr/data.
  - Accepted source with addr == 0 → handshake completes, but rf_we = 0 next cycle (dropped write).
  - No accept → rf_we = 0 next cycle. rf_addr/rf_data hold their previous values.
- Same-address collision (both valid, same addr): only the winner is written this cycle. The loser is written on a later cycle, so the later value wins in the register file. Required ordering: A before B unless forced.
- Back-to-back: a continuously valid source may be accepted every cycle. rf_we then stays high on consecutive cycles.
- Reset: rf_we = 0, rf_addr = 0, rf_data = 0, wait_cnt = 0.
  - a_ready/b_ready = 0 while rst is high, regardless of the valids.
  - Reset asserted mid-stream clears any registered-but-unused write command. The command is lost, and no rf_we follows reset deassertion.
- No X propagation: rf_addr/rf_data are defined whenever rf_we = 1.

Decomposition:
- Shared package rf_pkg:
  - Constants REG_ADDR_W = 5, REG_DATA_W = 32, ZERO_REG = 0.
  - Typedef rf_wr_cmd_t = {we, addr, data}, reused by the register file and the hazard unit.
- One natural sub-module: rf_starve_counter. It is the saturating wait counter with clear/increment/saturate and exposes at_max. The arbiter top holds the grant logic and the output register.

Test Plan:
- Single A write: a_valid=1, a_addr=5, a_data=0xDEADBEEF for 1 cycle → a_ready=1 that cycle; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF; the following cycle rf_we=0.
- Contention: A and B valid for 6 cycles, MAX_WAIT=4, B addr=7/data=0x11 → A granted on cycles 0-3 with wait_cnt 1,2,3,4; cycle 4 b_ready=1, b_starved=1, a_ready=0; cycle 5 rf_addr=7, rf_data=0x11; wait_cnt=0 after the grant.
- r0 drop: B valid, b_addr=0, b_data=0xFFFFFFFF → b_ready=1; next cycle rf_we=0.
- Same-address order: A addr=3/0xA, B addr=3/0xB, both valid → rf writes 0xA to r3 then 0xB to r3 on consecutive cycles.
- Reset mid-operation: accept A (addr=9), then assert rst in the same cycle edge window → rf_we=0 and wait_cnt=0 asynchronously; both readies stay 0 while rst is high; no write to r9 after release.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_pkg
// Description : Shared register-file constants and types. Used by the write
//               arbiter, the register file and the hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int ZERO_REG   = 0;

    // One write-port command as seen by the register file.
    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } rf_wr_cmd_t;

    // Which writeback source owns the write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } rf_grant_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : rf_starve_counter
// Description : Saturating starvation counter for writeback source B.
//               Counts consecutive cycles in which B is valid but not
//               accepted; any other cycle clears it.
// Ports       : clk, rst (async, active-high)
//               inc    - B valid and lost arbitration this cycle
//               count  - current counter value (registered)
//               at_max - count has reached MAX_WAIT
// Revision    : 1.0 - initial release
// ============================================================================
module rf_starve_counter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign at_max = (r_cnt == CNT_W'(MAX_WAIT));
    assign count  = r_cnt;

    always_comb begin
        w_cnt_nxt = '0;
        if (inc) begin
            w_cnt_nxt = at_max ? r_cnt : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule : rf_starve_counter
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register file's single write port between the
//               in-order writeback stage (A) and the multi-cycle unit
//               writeback (B). Fixed priority to A, with B force-granted
//               after MAX_WAIT consecutive lost cycles. The write command
//               is registered (1-cycle latency); writes to r0 are accepted
//               but never forwarded.
// Ports       : clk, rst (async, active-high)
//               a_valid/a_addr/a_data/a_ready - source A handshake
//               b_valid/b_addr/b_data/b_ready - source B handshake
//               rf_we/rf_addr/rf_data         - registered write command
//               b_starved - B is being force-granted this cycle
//               wait_cnt  - current starvation counter value
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              b_starved,
    output logic [3:0]        wait_cnt
);

    localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(ZERO_REG);

    rf_grant_t         w_grant;
    logic              w_force;
    logic              w_at_max;
    logic              w_fwd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;

    // ------------------------------------------------------------------
    // Starvation counter: B lost this cycle when valid but not granted.
    // ------------------------------------------------------------------
    rf_starve_counter #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (4)
    ) u_starve_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (b_valid && (w_grant != GRANT_B)),
        .count  (wait_cnt),
        .at_max (w_at_max)
    );

    // ------------------------------------------------------------------
    // Grant selection. The counter only sits at MAX_WAIT after B lost the
    // previous cycle, so b_valid is normally high there; the b_valid term
    // keeps a stray deassertion from blocking A.
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = GRANT_NONE;
        w_force = 1'b0;
        if (!rst) begin
            if (w_at_max && b_valid) begin
                w_grant = GRANT_B;
                w_force = 1'b1;
            end else if (a_valid) begin
                w_grant = GRANT_A;
            end else if (b_valid) begin
                w_grant = GRANT_B;
            end
        end
    end

    assign a_ready   = (w_grant == GRANT_A);
    assign b_ready   = (w_grant == GRANT_B);
    assign b_starved = w_force;

    always_comb begin
        w_sel_addr = a_addr;
        w_sel_data = a_data;
        if (w_grant == GRANT_B) begin
            w_sel_addr = b_addr;
            w_sel_data = b_data;
        end
    end

    // r0 writes complete the handshake but never reach the register file.
    assign w_fwd = (w_grant != GRANT_NONE) && (w_sel_addr != c_zero_addr);

    // ------------------------------------------------------------------
    // Registered write command. Address/data only move on a forwarded
    // write, so they hold their last value otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_we <= w_fwd;
            if (w_fwd) begin
                r_addr <= w_sel_addr;
                r_data <= w_sel_data;
            end
        end
    end

    assign rf_we   = r_we;
    assign rf_addr = r_addr;
    assign rf_data = r_data;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench for rf_write_arbiter. Directed scenarios
//               followed by random two-source traffic, compared cycle by
//               cycle against a behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst;
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic              b_starved;
    logic [3:0]        wait_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int                m_cnt;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              m_ga;
    logic              m_gb;
    logic [DATA_W-1:0] m_regfile [32];
    logic [DATA_W-1:0] d_regfile [32];

    rf_write_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .rf_we     (rf_we),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .b_starved (b_starved),
        .wait_cnt  (wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow register file fed by the DUT's write port.
    always @(posedge clk) begin
        if (rf_we === 1'b1) d_regfile[rf_addr] <= rf_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Called just after a negedge with inputs already driven. Checks the
    // combinational handshake, advances the model through the posedge and
    // checks the registered outputs at the following negedge.
    task automatic cycle_check();
        logic force_g;
        #1;
        force_g = (m_cnt == MAX_WAIT) && b_valid;
        m_ga    = a_valid && !force_g;
        m_gb    = b_valid && !m_ga;
        chk("a_ready",   a_ready,   m_ga);
        chk("b_ready",   b_ready,   m_gb);
        chk("b_starved", b_starved, force_g);

        m_we = 1'b0;
        if (m_ga && a_addr != 0) begin
            m_we = 1'b1; m_addr = a_addr; m_data = a_data;
        end else if (m_gb && b_addr != 0) begin
            m_we = 1'b1; m_addr = b_addr; m_data = b_data;
        end
        if (m_we) m_regfile[m_addr] = m_data;
        if (b_valid && !m_gb) m_cnt = (m_cnt + 1 > MAX_WAIT) ? MAX_WAIT : m_cnt + 1;
        else                  m_cnt = 0;

        @(negedge clk);
        chk("rf_we",    rf_we,    m_we);
        chk("rf_addr",  rf_addr,  m_addr);
        chk("rf_data",  rf_data,  m_data);
        chk("wait_cnt", wait_cnt, 4'(m_cnt));
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_regfile[i] = '0;
            d_regfile[i] = '0;
        end
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        a_valid = 1'b1; b_valid = 1'b1;
        #1;
        chk("rst_a_ready",  a_ready,  1'b0);
        chk("rst_b_ready",  b_ready,  1'b0);
        chk("rst_rf_we",    rf_we,    1'b0);
        chk("rst_rf_addr",  rf_addr,  '0);
        chk("rst_rf_data",  rf_data,  '0);
        chk("rst_wait_cnt", wait_cnt, '0);
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;

        // Single A write
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        cycle_check();
        chk("single_we",   rf_we,   1'b1);
        chk("single_addr", rf_addr, 5'd5);
        chk("single_data", rf_data, 32'hDEADBEEF);
        idle_inputs();
        cycle_check();
        chk("single_we_off", rf_we, 1'b0);

        // Contention: A wins four cycles, then B is forced
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h100;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h11;
        for (int i = 0; i < MAX_WAIT; i++) begin
            cycle_check();
            chk("cont_cnt", wait_cnt, 4'(i + 1));
            a_data = a_data + 1;
        end
        #1;
        chk("cont_force_b",  b_ready,   1'b1);
        chk("cont_force_st", b_starved, 1'b1);
        chk("cont_force_a",  a_ready,   1'b0);
        cycle_check();
        chk("cont_b_addr", rf_addr,  5'd7);
        chk("cont_b_data", rf_data,  32'h11);
        chk("cont_cnt_clr", wait_cnt, 4'd0);
        b_valid = 1'b0;
        cycle_check();
        idle_inputs();
        cycle_check();

        // r0 drop
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        cycle_check();
        chk("r0_drop_we", rf_we, 1'b0);
        idle_inputs();

        // Same-address ordering: A then B
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'hA;
        b_valid = 1'b1; b_addr = 5'd3; b_data = 32'hB;
        cycle_check();
        chk("order_first", rf_data, 32'hA);
        a_valid = 1'b0;
        cycle_check();
        chk("order_second", rf_data, 32'hB);
        idle_inputs();
        cycle_check();
        chk("order_rf_r3", d_regfile[3], 32'hB);

        // Reset mid-operation: command for r9 registered, then reset
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h99;
        #1;
        chk("rmid_accept", a_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        b_valid = 1'b1; b_addr = 5'd4;
        #1;
        chk("rmid_we",     rf_we,    1'b0);
        chk("rmid_cnt",    wait_cnt, 4'd0);
        chk("rmid_a_rdy",  a_ready,  1'b0);
        chk("rmid_b_rdy",  b_ready,  1'b0);
        model_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        cycle_check();
        chk("rmid_no_r9", d_regfile[9], 32'h0);

        // Random traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (m_ga || !a_valid) begin
                a_valid = ($urandom % 4) != 0;
                a_addr  = ADDR_W'($urandom % 8);
                a_data  = $urandom;
            end
            if (m_gb || !b_valid) begin
                b_valid = ($urandom % 2) != 0;
                b_addr  = ADDR_W'($urandom % 8);
                b_data  = $urandom;
            end
            cycle_check();
        end
        idle_inputs();
        cycle_check();
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            chk("regfile", d_regfile[i], m_regfile[i]);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
